pmem_arbiter: RTL

//  Shares the single 256-bit cacheline memory port (to the cacheline adaptor / burst memory)

---
 rtl/pmem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares one cacheline memory port between the I-cache (read only) and the
//   D-cache (read/write). One requester is granted at a time; its address and
//   writeback data are latched at grant time, and the memory response is routed
//   back to the granted side only. Ties go round-robin: the side that was not
//   served last wins the next tie (D wins the first tie after reset).
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   i_read, i_addr            I-cache line-read request and address
//   i_rdata, i_resp           line returned to the I-cache, 1-cycle completion pulse
//   d_read, d_write, d_addr   D-cache read / writeback request and address
//   d_wdata                   D-cache writeback line
//   d_rdata, d_resp           line returned to the D-cache, 1-cycle completion pulse
//   mem_read, mem_write       requests to the cacheline adaptor
//   mem_address, mem_wdata    latched address / writeback line of the granted request
//   mem_rdata, mem_resp       adaptor return line and completion pulse
//   busy                      high whenever a request is in service or in turnaround
//   dbg_state                 current FSM state (IDLE=0, SERVE_I=1, SERVE_D=2, DONE=3)
//
// Handshake: a requester raises x_read/x_write and holds it until x_resp; the
// arbiter holds mem_read/mem_write and the latched address/data constant until
// mem_resp, completes the requester in that same cycle, then spends one DONE
// cycle with no memory request so the served cache can drop its request line.

module pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic              prio_d;     // 1: D side wins the next tie
    logic              wflag;      // granted D request is a writeback
    logic [LINE_W-1:0] i_rdata_q;  // last line delivered to the I side
    logic [LINE_W-1:0] d_rdata_q;  // last line delivered to the D side

    logic d_req;
    logic grant_i, grant_d;
    logic done_i, done_d;

    assign d_req = d_read | d_write;

    // Next state and grant/complete strobes
    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        done_i   = 1'b0;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_read || prio_d)) begin
                    state_nx = SERVE_D;
                    grant_d  = 1'b1;
                end else if (i_read) begin
                    state_nx = SERVE_I;
                    grant_i  = 1'b1;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_nx = DONE;
                    done_i   = 1'b1;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_nx = DONE;
                    done_d   = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decode from the state and the latched write flag
    always_comb begin
        mem_read  = (state == SERVE_I) || ((state == SERVE_D) && !wflag);
        mem_write = (state == SERVE_D) && wflag;
        busy      = (state != IDLE);
        i_resp    = done_i;
        d_resp    = done_d;
        // Return data is passed through in the response cycle and held after it
        i_rdata   = done_i ? mem_rdata : i_rdata_q;
        d_rdata   = done_d ? mem_rdata : d_rdata_q;
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio_d      <= 1'b1;
            wflag       <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state <= state_nx;
            if (grant_i) begin
                mem_address <= i_addr;
                wflag       <= 1'b0;
            end
            if (grant_d) begin
                mem_address <= d_addr;
                mem_wdata   <= d_wdata;
                // A writeback takes precedence if read and write are both raised
                wflag       <= d_write;
            end
            if (done_i) begin
                i_rdata_q <= mem_rdata;
                prio_d    <= 1'b1;
            end
            if (done_d) begin
                d_rdata_q <= mem_rdata;
                prio_d    <= 1'b0;
            end
        end
    end

endmodule
